// File: rtl/circ_slot_alloc.sv
// Round-robin slot allocator: circular first-zero search from a
// rotating pointer, valid/ready allocate port, free port and flush.
module circ_slot_alloc #(
  parameter int W      = 32,
  parameter bit DIR_UP = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   alloc_vld_o,
  input  logic                   alloc_rdy_i,
  output logic [$clog2(W)-1:0]   alloc_id_o,
  output logic [W-1:0]           alloc_oh_o,
  input  logic                   free_vld_i,
  input  logic [$clog2(W)-1:0]   free_id_i,
  input  logic                   flush_i,
  output logic [W-1:0]           occ_o,
  output logic [$clog2(W+1)-1:0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   err_o
);

  localparam int LW = $clog2(W);
  localparam int CW = $clog2(W+1);

  logic [W-1:0]  occ_q, occ_d;
  logic [LW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic          found;
  logic [LW-1:0] srch_id;
  logic [LW-1:0] idx;
  logic          do_alloc;
  logic          free_ok;
  logic          free_bad;

  // Circular first-free search starting at ptr, from registered state only
  always_comb begin
    found   = 1'b0;
    srch_id = '0;
    idx     = '0;
    for (int k = 0; k < W; k++) begin
      idx = DIR_UP ? ptr_q + LW'(k)
                   : ptr_q - LW'(k);
      if (!found && !occ_q[idx]) begin
        found   = 1'b1;
        srch_id = idx;
      end
    end
  end

  assign alloc_vld_o = found;
  assign alloc_id_o  = srch_id;
  assign alloc_oh_o  = found
    ? ({{(W-1){1'b0}}, 1'b1} << srch_id)
    : '0;

  assign do_alloc = found & alloc_rdy_i;
  assign free_ok  = free_vld_i & occ_q[free_id_i];
  assign free_bad = free_vld_i & ~occ_q[free_id_i];

  // Next-state: flush wins; otherwise apply allocate and free together
  always_comb begin
    occ_d   = occ_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    if (flush_i) begin
      occ_d   = '0;
      ptr_d   = '0;
      count_d = '0;
    end else begin
      if (do_alloc) begin
        occ_d[srch_id] = 1'b1;
        ptr_d = DIR_UP ? srch_id + LW'(1)
                       : srch_id - LW'(1);
      end
      if (free_ok)
        occ_d[free_id_i] = 1'b0;
      if (free_bad)
        err_d = 1'b1;
      if (do_alloc && !free_ok)
        count_d = count_q + CW'(1);
      else if (!do_alloc && free_ok)
        count_d = count_q - CW'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign occ_o   = occ_q;
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(W));
  assign empty_o = (count_q == '0);
  assign err_o   = err_q;

endmodule

// File: tb/tb_circ_slot_alloc.sv
// Directed bench for circ_slot_alloc: one up-search and one
// down-search instance, hand-computed expectations.
module tb_circ_slot_alloc;

  logic        clk = 1'b0;
  logic        rst, rdy, fvld, flush;
  logic [4:0]  fid;
  logic        vld, full, empty, err;
  logic [4:0]  id;
  logic [31:0] oh, occ;
  logic [5:0]  cnt;

  logic        d_rst, d_rdy, d_fvld, d_flush;
  logic [4:0]  d_fid;
  logic        d_vld, d_full, d_empty, d_err;
  logic [4:0]  d_id;
  logic [31:0] d_oh, d_occ;
  logic [5:0]  d_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  circ_slot_alloc #(.W(32), .DIR_UP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .alloc_vld_o(vld), .alloc_rdy_i(rdy),
    .alloc_id_o(id), .alloc_oh_o(oh),
    .free_vld_i(fvld), .free_id_i(fid),
    .flush_i(flush), .occ_o(occ),
    .count_o(cnt), .full_o(full),
    .empty_o(empty), .err_o(err)
  );

  circ_slot_alloc #(.W(32), .DIR_UP(1'b0)) dut_dn (
    .clk(clk), .rst(d_rst),
    .alloc_vld_o(d_vld), .alloc_rdy_i(d_rdy),
    .alloc_id_o(d_id), .alloc_oh_o(d_oh),
    .free_vld_i(d_fvld), .free_id_i(d_fid),
    .flush_i(d_flush), .occ_o(d_occ),
    .count_o(d_cnt), .full_o(d_full),
    .empty_o(d_empty), .err_o(d_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b0; fvld = 1'b0;
    fid = '0; flush = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic free_one(input logic [4:0] f);
    fvld = 1'b1; fid = f;
    tick();
    fvld = 1'b0;
  endtask

  task automatic d_free_one(input logic [4:0] f);
    d_fvld = 1'b1; d_fid = f;
    tick();
    d_fvld = 1'b0;
  endtask

  task automatic fill_all();
    rdy = 1'b1;
    repeat (32) tick();
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (vld !== 1'b1 || id !== 5'd0 || oh !== 32'h1) begin
      n_fail++;
      $display("FAIL reset_offer vld=%b id=%0d oh=%h need 1/0/1",
               vld, id, oh);
    end
    n_chk++;
    if (occ !== 32'h0 || cnt !== 6'd0 || empty !== 1'b1
        || full !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state occ=%h cnt=%0d e=%b f=%b err=%b",
               occ, cnt, empty, full, err);
    end
  endtask

  task automatic test_fill();
    int bad = 0;
    rdy = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (vld !== 1'b1 || id !== 5'(i) || oh !== (32'h1 << i)) begin
        if (bad == 0)
          $display("FAIL fill_order step=%0d vld=%b id=%0d oh=%h",
                   i, vld, id, oh);
        bad++;
      end
      tick();
    end
    n_chk++;
    if (bad != 0) n_fail++;
    n_chk++;
    if (full !== 1'b1 || vld !== 1'b0 || cnt !== 6'd32
        || id !== 5'd0 || oh !== 32'h0) begin
      n_fail++;
      $display("FAIL fill_full f=%b vld=%b cnt=%0d id=%0d oh=%h",
               full, vld, cnt, id, oh);
    end
    tick();
    rdy = 1'b0;
    n_chk++;
    if (occ !== 32'hFFFF_FFFF || cnt !== 6'd32 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_when_full occ=%h cnt=%0d err=%b",
               occ, cnt, err);
    end
  endtask

  task automatic test_free_full();
    fvld = 1'b1; fid = 5'd5;
    n_chk++;
    if (vld !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bypass vld=%b need 0", vld);
    end
    tick();
    fvld = 1'b0;
    n_chk++;
    if (vld !== 1'b1 || id !== 5'd5 || cnt !== 6'd31) begin
      n_fail++;
      $display("FAIL refree vld=%b id=%0d cnt=%0d need 1/5/31",
               vld, id, cnt);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  task automatic test_search_up();
    for (int i = 0; i < 32; i++)
      if (i < 4 || i > 7) free_one(5'(i));
    n_chk++;
    if (occ !== 32'h0000_00F0 || cnt !== 6'd4 || id !== 5'd8) begin
      n_fail++;
      $display("FAIL search_up occ=%h cnt=%0d id=%0d need f0/4/8",
               occ, cnt, id);
    end
  endtask

  task automatic test_search_down();
    int bad = 0;
    d_rst = 1'b1; d_rdy = 1'b0; d_fvld = 1'b0;
    d_fid = '0; d_flush = 1'b0;
    tick();
    d_rst = 1'b0;
    d_rdy = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (d_id !== 5'((32 - i) % 32) || d_vld !== 1'b1) begin
        if (bad == 0)
          $display("FAIL down_order step=%0d id=%0d vld=%b",
                   i, d_id, d_vld);
        bad++;
      end
      tick();
    end
    d_rdy = 1'b0;
    n_chk++;
    if (bad != 0 || d_full !== 1'b1) n_fail++;
    d_free_one(5'd7);
    n_chk++;
    if (d_id !== 5'd7 || d_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL down_refree id=%0d need 7", d_id);
    end
    d_rdy = 1'b1;
    tick();
    d_rdy = 1'b0;
    for (int i = 0; i < 32; i++)
      if (i < 4 || i > 7) d_free_one(5'(i));
    n_chk++;
    if (d_occ !== 32'h0000_00F0 || d_id !== 5'd3) begin
      n_fail++;
      $display("FAIL search_dn occ=%h id=%0d need f0/3",
               d_occ, d_id);
    end
  endtask

  task automatic test_bad_free();
    free_one(5'd9);
    n_chk++;
    if (err !== 1'b1 || occ !== 32'h0000_00F0 || cnt !== 6'd4) begin
      n_fail++;
      $display("FAIL bad_free err=%b occ=%h cnt=%0d need 1/f0/4",
               err, occ, cnt);
    end
    repeat (3) tick();
    n_chk++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky err=%b need 1", err);
    end
  endtask

  task automatic test_flush_prio();
    flush = 1'b1; rdy = 1'b1;
    fvld = 1'b1; fid = 5'd4;
    tick();
    flush = 1'b0; rdy = 1'b0; fvld = 1'b0;
    n_chk++;
    if (occ !== 32'h0 || cnt !== 6'd0 || id !== 5'd0
        || empty !== 1'b1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_prio occ=%h cnt=%0d id=%0d err=%b",
               occ, cnt, id, err);
    end
  endtask

  task automatic test_flush_noerr();
    do_reset();
    rdy = 1'b1;
    repeat (2) tick();
    flush = 1'b1;
    fvld = 1'b1; fid = 5'd9;
    tick();
    flush = 1'b0; rdy = 1'b0; fvld = 1'b0;
    n_chk++;
    if (err !== 1'b0 || occ !== 32'h0 || cnt !== 6'd0
        || id !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_noerr err=%b occ=%h cnt=%0d id=%0d",
               err, occ, cnt, id);
    end
  endtask

  task automatic test_alloc_free();
    do_reset();
    fill_all();
    for (int i = 2; i < 31; i++)
      if (i != 7) free_one(5'(i));
    n_chk++;
    if (cnt !== 6'd4 || id !== 5'd2) begin
      n_fail++;
      $display("FAIL af_setup cnt=%0d id=%0d need 4/2", cnt, id);
    end
    rdy = 1'b1;
    fvld = 1'b1; fid = 5'd7;
    tick();
    rdy = 1'b0; fvld = 1'b0;
    n_chk++;
    if (cnt !== 6'd4 || occ !== 32'h8000_0007 || id !== 5'd3
        || err !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_free cnt=%0d occ=%h id=%0d err=%b",
               cnt, occ, id, err);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; rdy = 1'b1;
    fvld = 1'b1; fid = 5'd9;
    tick();
    rst = 1'b0; rdy = 1'b0; fvld = 1'b0;
    n_chk++;
    if (occ !== 32'h0 || cnt !== 6'd0 || err !== 1'b0
        || id !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid occ=%h cnt=%0d err=%b id=%0d",
               occ, cnt, err, id);
    end
    free_one(5'd2);
    n_chk++;
    if (err !== 1'b1 || cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL stale_free err=%b cnt=%0d need 1/0", err, cnt);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; fvld = 1'b0;
    fid = '0; flush = 1'b0;
    d_rst = 1'b1; d_rdy = 1'b0; d_fvld = 1'b0;
    d_fid = '0; d_flush = 1'b0;
    #1;
    test_reset();
    test_fill();
    test_free_full();
    test_search_up();
    test_search_down();
    test_bad_free();
    test_flush_prio();
    test_flush_noerr();
    test_alloc_free();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
